// File: rtl/procyon_ieu_mdu_if.sv
// Issue/result bundle between the reservation station, the MDU and the CDB arbiter.
// master drives the op; slave (the MDU) answers with ready and the completed result.
interface procyon_ieu_mdu_if #(
    parameter int unsigned OPTN_DATA_WIDTH    = 32,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = 5
);
    logic [2:0]                    i_mdu_func;
    logic [OPTN_DATA_WIDTH-1:0]    i_src_a;
    logic [OPTN_DATA_WIDTH-1:0]    i_src_b;
    logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag;
    logic                          i_valid;
    logic                          o_ready;
    logic [OPTN_DATA_WIDTH-1:0]    o_data;
    logic [OPTN_ROB_IDX_WIDTH-1:0] o_tag;
    logic                          o_exc;
    logic                          o_valid;

    modport master (
        output i_mdu_func, i_src_a, i_src_b, i_tag, i_valid,
        input  o_ready, o_data, o_tag, o_exc, o_valid
    );

    modport slave (
        input  i_mdu_func, i_src_a, i_src_b, i_tag, i_valid,
        output o_ready, o_data, o_tag, o_exc, o_valid
    );
endinterface

// File: rtl/procyon_ieu_mdu.sv
// Multi-cycle RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define PCYN_MDU_DIV_EN to build the divider; without it div ops complete at once with o_exc.
module procyon_ieu_mdu #(
    parameter int unsigned OPTN_DATA_WIDTH         = 32,
    parameter int unsigned OPTN_ROB_IDX_WIDTH      = 5,
    parameter int unsigned OPTN_MUL_BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    procyon_ieu_mdu_if.slave mdu
);
    localparam int unsigned W  = OPTN_DATA_WIDTH;
    localparam int unsigned B  = OPTN_MUL_BITS_PER_CYCLE;
    localparam int unsigned WB = W + B;
    localparam int unsigned CW = $clog2(W) + 1;
    localparam logic [CW-1:0] MulIters = CW'(W / B - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
    typedef enum logic [2:0] {
        FnMul, FnMulh, FnMulhsu, FnMulhu, FnDiv, FnDivu, FnRem, FnRemu
    } func_e;

    state_e                  state_q, state_d;
    func_e                   func_q, func_d, func_in;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_q, tag_d;
    logic [W-1:0]            opb_q, opb_d;
    logic [2*W-1:0]          prod_q, prod_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic [W-1:0]            data_q, data_d;
    logic                    exc_q, exc_d;

    logic                    accept, a_signed, b_signed, sa, sb;
    logic [W-1:0]            a_mag, b_mag;
    logic [WB-1:0]           mul_acc;
    logic [2*W-1:0]          mul_next, mul_fin;

    assign func_in     = func_e'(mdu.i_mdu_func);
    assign mdu.o_ready = (state_q == StIdle) && !rst;
    assign accept      = mdu.i_valid && mdu.o_ready && !i_flush;
    assign mdu.o_valid = (state_q == StDone) && !i_flush && !rst;
    assign mdu.o_data  = data_q;
    assign mdu.o_tag   = tag_q;
    assign mdu.o_exc   = exc_q;

    always_comb begin
        a_signed = func_in inside {FnMulh, FnMulhsu, FnDiv, FnRem};
        b_signed = func_in inside {FnMulh, FnDiv, FnRem};
        sa       = a_signed && mdu.i_src_a[W-1];
        sb       = b_signed && mdu.i_src_b[W-1];
        a_mag    = sa ? -mdu.i_src_a : mdu.i_src_a;
        b_mag    = sb ? -mdu.i_src_b : mdu.i_src_b;
    end

    // prod_q = {partial product, unconsumed multiplier bits}; B multiplier bits retire per step.
    always_comb begin
        mul_acc  = {{B{1'b0}}, prod_q[2*W-1:W]} + WB'(opb_q) * WB'(prod_q[B-1:0]);
        mul_next = {mul_acc, prod_q[W-1:B]};
        mul_fin  = neg_q ? -mul_next : mul_next;
    end

`ifdef PCYN_MDU_DIV_EN
    localparam logic [CW-1:0] DivIters = CW'(W - 1);

    logic         rneg_q, rneg_d;
    logic [W:0]   div_trial;
    logic [W-1:0] div_rem, div_quo, quo_fin, rem_fin;

    // Divide reuses prod_q as {partial remainder, dividend shifting into quotient}.
    always_comb begin
        div_trial = prod_q[2*W-1:W-1] - {1'b0, opb_q};
        if (div_trial[W]) begin
            div_rem = prod_q[2*W-2:W-1];
            div_quo = {prod_q[W-2:0], 1'b0};
        end else begin
            div_rem = div_trial[W-1:0];
            div_quo = {prod_q[W-2:0], 1'b1};
        end
        quo_fin = neg_q ? -div_quo : div_quo;
        rem_fin = rneg_q ? -div_rem : div_rem;
    end
`endif

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        tag_d   = tag_q;
        opb_d   = opb_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        data_d  = data_q;
        exc_d   = exc_q;
`ifdef PCYN_MDU_DIV_EN
        rneg_d  = rneg_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    func_d = func_in;
                    tag_d  = mdu.i_tag;
                    exc_d  = 1'b0;
                    neg_d  = sa ^ sb;
                    if (!mdu.i_mdu_func[2]) begin
                        state_d = StMul;
                        opb_d   = a_mag;
                        prod_d  = {{W{1'b0}}, b_mag};
                        cnt_d   = MulIters;
                    end else begin
`ifdef PCYN_MDU_DIV_EN
                        if (mdu.i_src_b == '0) begin
                            state_d = StDone;
                            data_d  = mdu.i_mdu_func[1] ? mdu.i_src_a : '1;
                        end else begin
                            state_d = StDiv;
                            opb_d   = b_mag;
                            prod_d  = {{W{1'b0}}, a_mag};
                            cnt_d   = DivIters;
                            rneg_d  = sa;
                        end
`else
                        state_d = StDone;
                        data_d  = '0;
                        exc_d   = 1'b1;
`endif
                    end
                end
            end
            StMul: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    data_d  = (func_q == FnMul) ? mul_fin[W-1:0] : mul_fin[2*W-1:W];
                end
            end
`ifdef PCYN_MDU_DIV_EN
            StDiv: begin
                prod_d = {div_rem, div_quo};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    data_d  = (func_q inside {FnDiv, FnDivu}) ? quo_fin : rem_fin;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (i_flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            func_q  <= FnMul;
            tag_q   <= '0;
            opb_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            data_q  <= '0;
            exc_q   <= 1'b0;
`ifdef PCYN_MDU_DIV_EN
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            tag_q   <= tag_d;
            opb_q   <= opb_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
`ifdef PCYN_MDU_DIV_EN
            rneg_q  <= rneg_d;
`endif
        end
    end
endmodule

// File: tb/tb_procyon_ieu_mdu.sv
// Randomised self-checking bench for procyon_ieu_mdu against a plain-arithmetic RV32M model.
// Expectations follow PCYN_MDU_DIV_EN the same way the design build does.
module tb_procyon_ieu_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_flush = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    procyon_ieu_mdu_if #(.OPTN_DATA_WIDTH(32), .OPTN_ROB_IDX_WIDTH(5)) bus ();

    procyon_ieu_mdu #(
        .OPTN_DATA_WIDTH(32),
        .OPTN_ROB_IDX_WIDTH(5),
        .OPTN_MUL_BITS_PER_CYCLE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_flush(i_flush),
        .mdu(bus)
    );

    // Returns {exc, data}.
    function automatic logic [32:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] sp;
        logic [31:0]        r;
        logic               e;
        e = 1'b0;
        r = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = sp[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            default: begin
`ifdef PCYN_MDU_DIV_EN
                if (b == 0) r = (f[1]) ? a : 32'hFFFF_FFFF;
                else if (f == 3'd4) r = (a == 32'h8000_0000 && b == '1) ? a : $signed(a) / $signed(b);
                else if (f == 3'd6) r = (a == 32'h8000_0000 && b == '1) ? 0 : $signed(a) % $signed(b);
                else if (f == 3'd5) r = a / b;
                else r = a % b;
`else
                e = 1'b1;
                r = '0;
`endif
            end
        endcase
        return {e, r};
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] b);
        if (f < 3'd4) return 32 / 2 + 1;
        if (b == 0) return 1;
`ifdef PCYN_MDU_DIV_EN
        return 33;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Issues one op in the next cycle and waits (bounded) for its result; lat = -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] d, output logic e,
                          output logic [4:0] ot, output int lat);
        @(posedge clk); #1;
        bus.i_mdu_func = f; bus.i_src_a = a; bus.i_src_b = b; bus.i_tag = t; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = -1; d = 'x; e = 1'bx; ot = 'x;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                d = bus.o_data; e = bus.o_exc; ot = bus.o_tag; lat = k + 1;
                break;
            end
        end
    endtask

    task automatic check_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t,
                            input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        logic [31:0] d; logic e; logic [4:0] ot; int lat;
        run_op(f, a, b, t, d, e, ot, lat);
        n_vec++;
        if (lat !== exp_lat) begin
            $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); n_err++;
        end
        n_vec++;
        if (d !== exp_d) begin
            $display("FAIL %s data f=%0d a=%h b=%h: got %h want %h", nm, f, a, b, d, exp_d); n_err++;
        end
        n_vec++;
        if (e !== exp_e) begin
            $display("FAIL %s exc: got %b want %b", nm, e, exp_e); n_err++;
        end
        n_vec++;
        if (ot !== t) begin
            $display("FAIL %s tag: got %0d want %0d", nm, ot, t); n_err++;
        end
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0; bus.i_mdu_func = '0; bus.i_src_a = '0; bus.i_src_b = '0; bus.i_tag = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.o_ready !== 1'b0) begin $display("FAIL reset o_ready: got %b want 0", bus.o_ready); n_err++; end
        n_vec++; if (bus.o_valid !== 1'b0) begin $display("FAIL reset o_valid: got %b want 0", bus.o_valid); n_err++; end
        n_vec++; if (bus.o_data !== 32'h0) begin $display("FAIL reset o_data: got %h want 0", bus.o_data); n_err++; end
        n_vec++; if (bus.o_tag !== 5'h0) begin $display("FAIL reset o_tag: got %h want 0", bus.o_tag); n_err++; end
        n_vec++; if (bus.o_exc !== 1'b0) begin $display("FAIL reset o_exc: got %b want 0", bus.o_exc); n_err++; end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.o_ready !== 1'b1) begin $display("FAIL post-reset o_ready: got %b want 1", bus.o_ready); n_err++; end
    endtask

    task automatic test_mul_directed();
        logic [2:0]  f  [4] = '{3'd3, 3'd0, 3'd1, 3'd2};
        logic [31:0] a  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h4000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            check_op($sformatf("mul_dir%0d", i), f[i], a[i], b[i], 5'(3 + i), ex[i], 1'b0, 17);
        end
    endtask

    task automatic test_div_directed();
        logic [2:0]  f  [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [4] = '{32'h2, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`ifdef PCYN_MDU_DIV_EN
        logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            check_op($sformatf("div_dir%0d", i), f[i], a[i], b[i], 5'(10 + i), ex[i], 1'b0, 33);
        end
`else
        for (int i = 0; i < 4; i++) begin
            check_op($sformatf("div_dir%0d", i), f[i], a[i], b[i], 5'(10 + i), 32'h0, 1'b1, 1);
        end
        check_op("div_9_3", 3'd4, 32'd9, 32'd3, 5'd14, 32'h0, 1'b1, 1);
`endif
    endtask

    task automatic test_div_by_zero();
        logic [31:0] d; logic e; logic [4:0] ot; int lat;
        logic [2:0]  f  [2] = '{3'd5, 3'd6};
`ifdef PCYN_MDU_DIV_EN
        logic [31:0] ex [2] = '{32'hFFFF_FFFF, 32'h5};
`else
        logic [31:0] ex [2] = '{32'h0, 32'h0};
`endif
        for (int i = 0; i < 2; i++) begin
            run_op(f[i], 32'd5, 32'd0, 5'(20 + i), d, e, ot, lat);
            n_vec++; if (lat !== 1) begin $display("FAIL dbz%0d latency: got %0d want 1", i, lat); n_err++; end
            n_vec++; if (d !== ex[i]) begin $display("FAIL dbz%0d data: got %h want %h", i, d, ex[i]); n_err++; end
            n_vec++; if (bus.o_ready !== 1'b0) begin $display("FAIL dbz%0d ready in done: got %b want 0", i, bus.o_ready); n_err++; end
            @(negedge clk);
            n_vec++; if (bus.o_ready !== 1'b1) begin $display("FAIL dbz%0d ready after: got %b want 1", i, bus.o_ready); n_err++; end
            n_vec++; if (bus.o_valid !== 1'b0) begin $display("FAIL dbz%0d valid not pulse: got %b want 0", i, bus.o_valid); n_err++; end
        end
    endtask

    // Flush is held high for the cycle after edge k (edge 0 = accept).
    task automatic flush_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input int k);
        int   seen = 0;
        logic rdy_after = 1'b0;
        @(posedge clk); #1;
        bus.i_mdu_func = f; bus.i_src_a = a; bus.i_src_b = b; bus.i_tag = 5'd30; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (c == k) i_flush = 1'b1;
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen++;
            if (c == k + 1) rdy_after = bus.o_ready;
            @(posedge clk); #1;
            if (c == k) i_flush = 1'b0;
        end
        n_vec++; if (seen !== 0) begin $display("FAIL %s o_valid pulses: got %0d want 0", nm, seen); n_err++; end
        n_vec++; if (rdy_after !== 1'b1) begin $display("FAIL %s ready after flush: got %b want 1", nm, rdy_after); n_err++; end
    endtask

    task automatic test_flush();
        int dl;
        dl = ref_lat(3'd4, 32'd7);
        flush_op("flush_div_mid", 3'd4, 32'd100, 32'd7, (dl > 10) ? 9 : dl - 1);
        flush_op("flush_div_done", 3'd4, 32'd100, 32'd7, dl - 1);
        flush_op("flush_mul_mid", 3'd0, 32'd12345, 32'd678, 9);
        flush_op("flush_mul_done", 3'd1, 32'h8000_0000, 32'h3, 16);
        // Flush together with a request: nothing must be captured.
        @(posedge clk); #1;
        bus.i_mdu_func = 3'd0; bus.i_src_a = 32'd3; bus.i_src_b = 32'd4; bus.i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.o_ready !== 1'b1) begin $display("FAIL flush_accept captured: ready got %b want 1", bus.o_ready); n_err++; end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(posedge clk); #1;
        bus.i_mdu_func = 3'd0; bus.i_src_a = 32'd77; bus.i_src_b = 32'd3; bus.i_tag = 5'd9; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.o_ready !== 1'b0) begin $display("FAIL rst_mid ready during rst: got %b want 0", bus.o_ready); n_err++; end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.o_ready !== 1'b1) begin $display("FAIL rst_mid ready: got %b want 1", bus.o_ready); n_err++; end
        n_vec++; if (bus.o_data !== 32'h0) begin $display("FAIL rst_mid o_data: got %h want 0", bus.o_data); n_err++; end
        n_vec++; if (bus.o_tag !== 5'h0) begin $display("FAIL rst_mid o_tag: got %h want 0", bus.o_tag); n_err++; end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin $display("FAIL rst_mid stray o_valid: got %0d want 0", seen); n_err++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [2:0]  f;
        logic [32:0] r;
        for (int i = 0; i < 8; i++) begin
            f = 3'(i);
            a = $urandom(); b = $urandom();
            r = ref_mdu(f, a, b);
            check_op($sformatf("b2b%0d", i), f, a, b, 5'(i), r[31:0], r[32], ref_lat(f, b));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  f;
        logic [32:0] r;
        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick(); b = pick();
            r = ref_mdu(f, a, b);
            check_op($sformatf("rnd%0d", i), f, a, b, 5'($urandom()), r[31:0], r[32], ref_lat(f, b));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_div_by_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
